// File: rtl/alu_seq.sv
// Handshaked ALU with iterative signed multiply (shift-add) and divide (restoring).
// ALU ops complete in one edge; MUL/DIV take WIDTH+1 edges from accept to out_valid.
module alu_seq #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int CNT_W   = $clog2(WIDTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d, result_q, result_d;
  logic             neg_q, neg_d, is_div_q, is_div_d, dbz_q, dbz_d;
  logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d;

  logic [2:0]       op;
  logic             accept, a_neg, b_neg, add_ovf, sub_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, sum, diff;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_addend, rem_sh, step_hi, step_lo, fixed;
  logic             rem_ge, mul_ovf, div_ovf;
  logic             unused_opc_bits;

  assign unused_opc_bits = ^ctrl_ALUopcode[4:3];
  assign op       = ctrl_ALUopcode[2:0];
  assign in_ready = ((state_q == IDLE) | ((state_q == DONE) & out_ready)) & reset_n;
  assign accept   = in_valid & in_ready;

  assign a_neg   = data_operandA[WIDTH-1];
  assign b_neg   = data_operandB[WIDTH-1];
  assign a_mag   = a_neg ? -data_operandA : data_operandA;
  assign b_mag   = b_neg ? -data_operandB : data_operandB;
  assign sum     = data_operandA + data_operandB;
  assign diff    = data_operandA - data_operandB;
  assign add_ovf = (a_neg == b_neg) & (sum[WIDTH-1] != a_neg);
  assign sub_ovf = (a_neg != b_neg) & (diff[WIDTH-1] != a_neg);

  // {hi,lo} is the product register for MUL, {remainder,quotient} for DIV.
  assign mul_addend = lo_q[0] ? mag_q : '0;
  assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
  assign rem_sh     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign rem_ge     = rem_sh >= mag_q;

  always_comb begin
    if (is_div_q) begin
      step_hi = rem_ge ? rem_sh - mag_q : rem_sh;
      step_lo = {lo_q[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // A negated magnitude may reach exactly 2^(WIDTH-1) and still fit.
  assign fixed   = neg_q ? -step_lo : step_lo;
  assign mul_ovf = (|step_hi) |
                   (neg_q ? (step_lo[WIDTH-1] & (|step_lo[WIDTH-2:0])) : step_lo[WIDTH-1]);
  assign div_ovf = ~dbz_q & ~neg_q & step_lo[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;

    case (state_q)
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = (is_div_q & dbz_q) ? '0 : fixed;
          ovf_d    = is_div_q ? div_ovf : mul_ovf;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      state_d  = DONE;
      ne_d     = data_operandA != data_operandB;
      lt_d     = $signed(data_operandA) < $signed(data_operandB);
      ovf_d    = 1'b0;
      dbz_d    = 1'b0;
      neg_d    = a_neg ^ b_neg;
      is_div_d = op[0];
      case (op)
        3'b000: begin result_d = sum;  ovf_d = add_ovf; end
        3'b001: begin result_d = diff; ovf_d = sub_ovf; end
        3'b010: result_d = data_operandA & data_operandB;
        3'b011: result_d = data_operandA | data_operandB;
        3'b100: result_d = data_operandA << ctrl_shiftamt;
        3'b101: result_d = $signed(data_operandA) >>> ctrl_shiftamt;
        default: begin
          state_d = BUSY;
          cnt_d   = CNT_W'(WIDTH);
          hi_d    = '0;
          mag_d   = op[0] ? b_mag : a_mag;
          lo_d    = op[0] ? a_mag : b_mag;
          dbz_d   = op[0] & (data_operandB == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid   = (state_q == DONE);
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance sharing clock and reset.
module tb_alu_seq;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, ne, lt, ovf, dbz;
  logic [31:0] a, b, res;
  logic [4:0]  opc, sh;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, ne8, lt8, ovf8, dbz8;
  logic [7:0]  a8, b8, res8;
  logic [4:0]  opc8;
  logic [2:0]  sh8;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_operandA(a), .data_operandB(b), .ctrl_ALUopcode(opc), .ctrl_shiftamt(sh),
    .out_valid(out_valid), .out_ready(out_ready), .data_result(res),
    .isNotEqual(ne), .isLessThan(lt), .overflow(ovf), .div_by_zero(dbz)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .data_operandA(a8), .data_operandB(b8), .ctrl_ALUopcode(opc8), .ctrl_shiftamt(sh8),
    .out_valid(out_valid8), .out_ready(out_ready8), .data_result(res8),
    .isNotEqual(ne8), .isLessThan(lt8), .overflow(ovf8), .div_by_zero(dbz8)
  );

  // Drives one op on the 32-bit instance and returns when out_valid is seen (or bound expires).
  task automatic do_op32(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] shv, output int lat);
    int guard = 0;
    out_ready = 1'b1;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL op32_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1; opc = op; a = av; b = bv; sh = shv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; opc = OP_ADD; sh = 5'd31;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    $display("txn32 op=%0d a=%h b=%h sh=%0d -> res=%h ne=%b lt=%b ovf=%b dbz=%b lat=%0d",
             op[2:0], av, bv, shv, res, ne, lt, ovf, dbz, lat);
  endtask

  task automatic do_op8(input logic [4:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] shv, output int lat);
    int guard = 0;
    out_ready8 = 1'b1;
    while (!in_ready8 && guard < 200) begin @(posedge clk); #1; guard++; end
    total++;
    if (in_ready8 !== 1'b1) begin bad++; $display("FAIL op8_in_ready: got %b want 1", in_ready8); end
    in_valid8 = 1'b1; opc8 = op; a8 = av; b8 = bv; sh8 = shv;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
    lat = 1;
    while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
    $display("txn8 op=%0d a=%h b=%h sh=%0d -> res=%h ne=%b lt=%b ovf=%b dbz=%b lat=%0d",
             op[2:0], av, bv, shv, res8, ne8, lt8, ovf8, dbz8, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    a = '0; b = '0; opc = '0; sh = '0; a8 = '0; b8 = '0; opc8 = '0; sh8 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, ne, lt, ovf, dbz} !== 6'b0 || res !== 32'h0) begin
      bad++; $display("FAIL reset32: got rdy/vld/ne/lt/ovf/dbz=%b res=%h want 0", {in_ready, out_valid, ne, lt, ovf, dbz}, res);
    end
    total++;
    if ({in_ready8, out_valid8, ne8, lt8, ovf8, dbz8} !== 6'b0 || res8 !== 8'h0) begin
      bad++; $display("FAIL reset8: got rdy/vld/ne/lt/ovf/dbz=%b res=%h want 0", {in_ready8, out_valid8, ne8, lt8, ovf8, dbz8}, res8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({in_ready, in_ready8} !== 2'b11) begin bad++; $display("FAIL reset_release_ready: got %b want 11", {in_ready, in_ready8}); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; opc = OP_ADD; a = 32'h7FFFFFFF; b = 32'h1; sh = '0;
    @(posedge clk); #1;
    $display("txn32 ADD -> vld=%b res=%h ovf=%b", out_valid, res, ovf);
    total++;
    if (out_valid !== 1'b1 || res !== 32'h80000000 || ovf !== 1'b1) begin
      bad++; $display("FAIL b2b_add: got vld=%b res=%h ovf=%b want 1 80000000 1", out_valid, res, ovf);
    end
    opc = 5'b11001; a = 32'd5; b = 32'd7;   // SUB with the ignored opcode bits set
    @(posedge clk); #1;
    $display("txn32 SUB -> vld=%b res=%h lt=%b ne=%b", out_valid, res, lt, ne);
    total++;
    if (out_valid !== 1'b1 || res !== 32'hFFFFFFFE || lt !== 1'b1 || ne !== 1'b1 || ovf !== 1'b0) begin
      bad++; $display("FAIL b2b_sub: got vld=%b res=%h lt=%b ne=%b ovf=%b want 1 fffffffe 1 1 0", out_valid, res, lt, ne, ovf);
    end
    opc = OP_SRA; a = 32'h80000000; b = 32'h0; sh = 5'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn32 SRA -> vld=%b res=%h", out_valid, res);
    total++;
    if (out_valid !== 1'b1 || res !== 32'hF8000000 || lt !== 1'b1 || ne !== 1'b1) begin
      bad++; $display("FAIL b2b_sra: got vld=%b res=%h lt=%b ne=%b want 1 f8000000 1 1", out_valid, res, lt, ne);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got vld=%b want 0", out_valid); end
  endtask

  task automatic test_logic();
    int lat;
    do_op32(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat);
    total++;
    if (res !== 32'hF000F000 || lat != 1) begin bad++; $display("FAIL and: got %h lat=%0d want f000f000 lat=1", res, lat); end
    do_op32(OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, lat);
    total++;
    if (res !== 32'hFFF0FFF0) begin bad++; $display("FAIL or: got %h want fff0fff0", res); end
    do_op32(OP_SLL, 32'h80000003, 32'h0, 5'd4, lat);
    total++;
    if (res !== 32'h00000030 || lt !== 1'b1) begin bad++; $display("FAIL sll: got %h lt=%b want 00000030 lt=1", res, lt); end
  endtask

  task automatic test_mul();
    int lat;
    logic rdy_seen;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; opc = OP_MUL; a = -32'sd6; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    $display("txn32 MUL -6*7 -> res=%h ovf=%b lat=%0d", res, ovf, lat);
    total++;
    if (lat != 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
    total++;
    if (rdy_seen !== 1'b0) begin bad++; $display("FAIL mul_busy_ready: got ready=1 while busy want 0"); end
    total++;
    if (res !== 32'hFFFFFFD6 || ovf !== 1'b0 || ne !== 1'b1 || lt !== 1'b1) begin
      bad++; $display("FAIL mul_neg: got res=%h ovf=%b ne=%b lt=%b want ffffffd6 0 1 1", res, ovf, ne, lt);
    end
    do_op32(OP_MUL, 32'h00010000, 32'h00010000, 5'd0, lat);
    total++;
    if (res !== 32'h0 || ovf !== 1'b1) begin bad++; $display("FAIL mul_big: got res=%h ovf=%b want 0 1", res, ovf); end
    do_op32(OP_MUL, 32'h80000000, 32'h1, 5'd0, lat);
    total++;
    if (res !== 32'h80000000 || ovf !== 1'b0) begin bad++; $display("FAIL mul_min_x1: got res=%h ovf=%b want 80000000 0", res, ovf); end
    do_op32(OP_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd0, lat);
    total++;
    if (res !== 32'h80000000 || ovf !== 1'b1) begin bad++; $display("FAIL mul_min_xm1: got res=%h ovf=%b want 80000000 1", res, ovf); end
    do_op32(OP_MUL, 32'd1000, -32'sd1000, 5'd0, lat);
    total++;
    if (res !== 32'hFFF0BDC0 || ovf !== 1'b0 || lt !== 1'b0) begin bad++; $display("FAIL mul_k: got res=%h ovf=%b lt=%b want fff0bdc0 0 0", res, ovf, lt); end
  endtask

  task automatic test_div();
    int lat;
    do_op32(OP_DIV, -32'sd7, 32'd2, 5'd0, lat);
    total++;
    if (res !== 32'hFFFFFFFD || ovf !== 1'b0 || dbz !== 1'b0) begin bad++; $display("FAIL div_neg: got res=%h ovf=%b dbz=%b want fffffffd 0 0", res, ovf, dbz); end
    do_op32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, lat);
    total++;
    if (res !== 32'h80000000 || ovf !== 1'b1) begin bad++; $display("FAIL div_min: got res=%h ovf=%b want 80000000 1", res, ovf); end
    do_op32(OP_DIV, 32'd9, 32'd0, 5'd0, lat);
    total++;
    if (res !== 32'h0 || dbz !== 1'b1 || ovf !== 1'b0 || lat != 33) begin
      bad++; $display("FAIL div_zero: got res=%h dbz=%b ovf=%b lat=%0d want 0 1 0 33", res, dbz, ovf, lat);
    end
    do_op32(OP_DIV, 32'd100, -32'sd7, 5'd0, lat);
    total++;
    if (res !== 32'hFFFFFFF2 || dbz !== 1'b0) begin bad++; $display("FAIL div_100_m7: got res=%h dbz=%b want fffffff2 0", res, dbz); end
    do_op32(OP_DIV, -32'sd100, -32'sd7, 5'd0, lat);
    total++;
    if (res !== 32'd14 || ovf !== 1'b0) begin bad++; $display("FAIL div_m100_m7: got res=%h ovf=%b want 0000000e 0", res, ovf); end
  endtask

  task automatic test_backpressure();
    logic stable_ok;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; opc = OP_ADD; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    $display("txn32 ADD 3+4 held -> vld=%b res=%h", out_valid, res);
    opc = OP_SUB; a = 32'd10; b = 32'd4;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || res !== 32'd7 || ne !== 1'b1 || lt !== 1'b1 || ovf !== 1'b0 || in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    total++;
    if (stable_ok !== 1'b1) begin
      bad++; $display("FAIL bp_hold: got vld=%b res=%h ne=%b lt=%b rdy=%b want 1 00000007 1 1 0", out_valid, res, ne, lt, in_ready);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_on_release: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn32 SUB 10-4 after release -> vld=%b res=%h", out_valid, res);
    total++;
    if (out_valid !== 1'b1 || res !== 32'd6 || lt !== 1'b0 || ne !== 1'b1) begin
      bad++; $display("FAIL bp_new_op: got vld=%b res=%h lt=%b ne=%b want 1 00000006 0 1", out_valid, res, lt, ne);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    logic vld_seen;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; opc = OP_MUL; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || res !== 32'h0) begin
      bad++; $display("FAIL mid_reset_asserted: got vld=%b rdy=%b res=%h want 0 0 0", out_valid, in_ready, res);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vld_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) vld_seen = 1'b1;
    end
    total++;
    if (vld_seen !== 1'b0) begin bad++; $display("FAIL mid_reset_no_output: got out_valid=1 want 0"); end
    do_op32(OP_MUL, 32'h00001234, -32'sd3, 5'd0, lat);
    total++;
    if (res !== 32'hFFFFC964 || lat != 33) begin bad++; $display("FAIL mid_reset_next_op: got res=%h lat=%0d want ffffc964 33", res, lat); end
  endtask

  task automatic test_w8();
    int lat;
    do_op8(OP_ADD, 8'h7F, 8'h01, 3'd0, lat);
    total++;
    if (res8 !== 8'h80 || ovf8 !== 1'b1 || lat != 1) begin bad++; $display("FAIL w8_add: got res=%h ovf=%b lat=%0d want 80 1 1", res8, ovf8, lat); end
    do_op8(OP_SUB, 8'd5, 8'd7, 3'd0, lat);
    total++;
    if (res8 !== 8'hFE || lt8 !== 1'b1 || ne8 !== 1'b1) begin bad++; $display("FAIL w8_sub: got res=%h lt=%b ne=%b want fe 1 1", res8, lt8, ne8); end
    do_op8(OP_SRA, 8'h80, 8'h00, 3'd4, lat);
    total++;
    if (res8 !== 8'hF8) begin bad++; $display("FAIL w8_sra: got %h want f8", res8); end
    do_op8(OP_MUL, 8'hFA, 8'h07, 3'd0, lat);
    total++;
    if (res8 !== 8'hD6 || ovf8 !== 1'b0 || lat != 9) begin bad++; $display("FAIL w8_mul: got res=%h ovf=%b lat=%0d want d6 0 9", res8, ovf8, lat); end
    do_op8(OP_MUL, 8'h10, 8'h10, 3'd0, lat);
    total++;
    if (res8 !== 8'h00 || ovf8 !== 1'b1) begin bad++; $display("FAIL w8_mul_big: got res=%h ovf=%b want 00 1", res8, ovf8); end
    do_op8(OP_DIV, 8'hF9, 8'h02, 3'd0, lat);
    total++;
    if (res8 !== 8'hFD || ovf8 !== 1'b0) begin bad++; $display("FAIL w8_div: got res=%h ovf=%b want fd 0", res8, ovf8); end
    do_op8(OP_DIV, 8'h80, 8'hFF, 3'd0, lat);
    total++;
    if (res8 !== 8'h80 || ovf8 !== 1'b1) begin bad++; $display("FAIL w8_div_min: got res=%h ovf=%b want 80 1", res8, ovf8); end
    do_op8(OP_DIV, 8'd9, 8'd0, 3'd0, lat);
    total++;
    if (res8 !== 8'h00 || dbz8 !== 1'b1 || ovf8 !== 1'b0 || lat != 9) begin
      bad++; $display("FAIL w8_div_zero: got res=%h dbz=%b ovf=%b lat=%0d want 00 1 0 9", res8, dbz8, ovf8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_logic();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
